hazard_tracker: RTL

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline, generalising the fixed EX/MEM/WB hazard unit to any number of in-flight stages after decode and any load-result latency. It tracks the destination register of every instruction between EX and WB, computes the decode-stage load-use stall and the EX-stage forwarding selects, and applies branch flush and exception hold. It also keeps saturating stall and flush counters for performance debug. It sits beside the decoder and drives the ID/EX pipe-register enable and reset and the EX operand muxes.

---
 rtl/hazard_tracker.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: load-use stall, EX forwarding selects, branch flush and
// exception hold for an in-order pipeline with DEPTH tracked stages after ID
// (slot 0 = EX, slot DEPTH-1 = WB).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_id_*                  decode-stage instruction: valid, sources (+used), dest, regwrite, load
//   i_flush                 branch taken in EX: discard the ID instruction
//   i_hold                  exception freeze: nothing advances, counters frozen
//   o_stall                 hold IF/ID and bubble EX (combinational)
//   o_issue                 ID instruction enters slot 0 at the next edge
//   o_fwd1_sel, o_fwd2_sel  EX operand source: 0 = register file, k = slot k result
//   o_stall_cnt, o_flush_cnt saturating event counters
module hazard_tracker #(
  parameter int RW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int FW         = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_id_valid,
  input  logic [RW-1:0] i_id_rs1n,
  input  logic [RW-1:0] i_id_rs2n,
  input  logic          i_id_rs1_used,
  input  logic          i_id_rs2_used,
  input  logic [RW-1:0] i_id_rdn,
  input  logic          i_id_regwrite,
  input  logic          i_id_memtoreg,
  input  logic          i_flush,
  input  logic          i_hold,
  output logic          o_stall,
  output logic          o_issue,
  output logic [FW-1:0] o_fwd1_sel,
  output logic [FW-1:0] o_fwd2_sel,
  output logic [31:0]   o_stall_cnt,
  output logic [31:0]   o_flush_cnt
);

  // Slot state, bit/element k = slot k.
  logic [DEPTH-1:0]         r_v, r_we, r_ld;
  logic [DEPTH-1:0][RW-1:0] r_rd;
  logic [RW-1:0]            r_ex_rs1n, r_ex_rs2n;
  logic                     r_ex_rs1_used, r_ex_rs2_used;
  logic [31:0]              r_stall_cnt, r_flush_cnt;

  logic          w_stall, w_load_hit, w_issue;
  logic [FW-1:0] w_fwd1, w_fwd2;

  always_comb begin
    w_load_hit = 1'b0;
    // Only loads still short of LOAD_READY (slots 0..LOAD_READY-2) can't be forwarded.
    for (int k = 0; k < DEPTH; k++) begin
      if (k < LOAD_READY - 1 && r_v[k] && r_we[k] && r_ld[k] &&
          ((i_id_rs1_used && i_id_rs1n != '0 && r_rd[k] == i_id_rs1n) ||
           (i_id_rs2_used && i_id_rs2n != '0 && r_rd[k] == i_id_rs2n)))
        w_load_hit = 1'b1;
    end
    // Flush wins over stall: the ID instruction is being discarded anyway.
    w_stall = w_load_hit & i_id_valid & ~i_flush;
    w_issue = i_id_valid & ~w_stall & ~i_flush & ~i_hold;

    // Scan oldest to youngest so the youngest producer (smallest k) wins.
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (r_v[k] && r_we[k] && r_ex_rs1_used && r_ex_rs1n != '0 && r_rd[k] == r_ex_rs1n)
        w_fwd1 = FW'(k);
      if (r_v[k] && r_we[k] && r_ex_rs2_used && r_ex_rs2n != '0 && r_rd[k] == r_ex_rs2n)
        w_fwd2 = FW'(k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_v           <= '0;
      r_we          <= '0;
      r_ld          <= '0;
      r_rd          <= '0;
      r_ex_rs1n     <= '0;
      r_ex_rs2n     <= '0;
      r_ex_rs1_used <= 1'b0;
      r_ex_rs2_used <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else if (!i_hold) begin
      // Slots shift toward WB; slot 0 takes the issued instruction or a bubble.
      r_v  <= {r_v[DEPTH-2:0],  w_issue};
      r_we <= {r_we[DEPTH-2:0], w_issue & i_id_regwrite};
      r_ld <= {r_ld[DEPTH-2:0], w_issue & i_id_memtoreg};
      r_rd <= {r_rd[DEPTH-2:0], i_id_rdn};
      r_ex_rs1n     <= w_issue ? i_id_rs1n : '0;
      r_ex_rs2n     <= w_issue ? i_id_rs2n : '0;
      r_ex_rs1_used <= w_issue & i_id_rs1_used;
      r_ex_rs2_used <= w_issue & i_id_rs2_used;
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall     = w_stall;
  assign o_issue     = w_issue;
  assign o_fwd1_sel  = w_fwd1;
  assign o_fwd2_sel  = w_fwd2;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
